// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter and the memory block it drives:
// sequencer state encoding and the memory mode flag values.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  localparam logic MMODE_READ  = 1'b0;
  localparam logic MMODE_WRITE = 1'b1;

  // Width of a requester index / round-robin pointer for 2..4 requesters.
  function automatic int ptr_width(input int n_req);
    return (n_req > 2) ? 2 : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin selector: first valid requester at or above ptr,
// wrapping modulo N_REQ. Returns one-hot grant, its index and an any flag.
module rr_picker #(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  // Scan from the farthest offset down so the nearest valid requester wins.
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (valid[PTR_W'(j)]) begin
        grant              = '0;
        grant[PTR_W'(j)]   = 1'b1;
        idx                = PTR_W'(j);
        any                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one word memory between N_REQ requesters.
// Optional WAIT watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ-1:0]    req_mode,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]    req_grant,
  output logic [N_REQ-1:0]    req_done,
  output logic [DATA_W-1:0]   rdata,
  output logic                err,
  output logic                mem_request,
  output logic                mem_mode,
  output logic [ADDR_W-1:0]   mem_locator,
  output logic [DATA_W-1:0]   mem_write_bus,
  input  logic [DATA_W-1:0]   mem_read_bus,
  input  logic                mem_response
);

  localparam int PTR_W = ptr_width(N_REQ);

  if (N_REQ < 2 || N_REQ > 4 || TIMEOUT < 1) begin : g_param_check
    $error("mem_arbiter: N_REQ must be 2..4 and TIMEOUT at least 1");
  end

  arb_state_t       state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] owner;
  logic [N_REQ-1:0] pick_grant;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_any;
  logic             timed_out;

  logic [ADDR_W-1:0] addr_arr  [N_REQ];
  logic [DATA_W-1:0] wdata_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Fires on the TIMEOUT-th edge spent in WAIT without a response.
  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT && !mem_response && !timed_out) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      owner         <= '0;
      req_grant     <= '0;
      req_done      <= '0;
      rdata         <= '0;
      err           <= 1'b0;
      mem_request   <= 1'b0;
      mem_mode      <= MMODE_READ;
      mem_locator   <= '0;
      mem_write_bus <= '0;
    end else begin
      req_grant <= '0;
      req_done  <= '0;
      err       <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A response still high from before a reset must clear first.
          if (pick_any && !mem_response) begin
            mem_request   <= 1'b1;
            mem_mode      <= req_mode[pick_idx];
            mem_locator   <= addr_arr[pick_idx];
            mem_write_bus <= wdata_arr[pick_idx];
            req_grant     <= pick_grant;
            owner         <= pick_idx;
            ptr           <= (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Request drops on the response edge so the memory sees it low at its next negedge.
          if (mem_response) begin
            mem_request <= 1'b0;
            if (mem_mode != MMODE_WRITE) rdata <= mem_read_bus;
            req_done    <= N_REQ'(1) << owner;
            state       <= ST_RELEASE;
          end else if (timed_out) begin
            mem_request <= 1'b0;
            err         <= 1'b1;
            req_done    <= N_REQ'(1) << owner;
            state       <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!mem_response) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single 16-bit word memory (request/response flag handshake, negedge-sampled) between N_REQ requesters, e.g. instruction fetch and load/store unit. It latches one requester's command, drives the memory request until the response flag is seen, returns read data, and guarantees that the request is dropped in time so one command never triggers two memory accesses.

Parameters:
N_REQ, 2, number of requesters (2..4)
ADDR_W, 16, locator width
DATA_W, 16, data word width
TIMEOUT, 15, watchdog limit in cycles for WAIT (used only with MEM_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock; all arbiter logic on posedge
reset  in  1  synchronous, active-high
req_valid  in  N_REQ  per-requester command valid; held with fields stable until req_done
req_mode  in  N_REQ  per-requester mode: 0 = read, 1 = write
req_addr  in  N_REQ*ADDR_W  packed locators; requester i at bits [i*ADDR_W +: ADDR_W]
req_wdata  in  N_REQ*DATA_W  packed write data
req_grant  out  N_REQ  one-hot, one-cycle pulse when a command is latched
req_done  out  N_REQ  one-hot, one-cycle pulse when the access has completed
rdata  out  DATA_W  read data of the last completed read; held until the next read completes
err  out  1  one-cycle timeout pulse (tied 0 without MEM_ARB_TIMEOUT_EN)
mem_request  out  1  to memory request_flag
mem_mode  out  1  to memory mode_flag
mem_locator  out  ADDR_W  to memory locator
mem_write_bus  out  DATA_W  to memory write_bus
mem_read_bus  in  DATA_W  from memory read_bus
mem_response  in  1  from memory response_flag

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Round-robin pointer 0.
  - Timeout counter 0.
- All mem_* outputs are registered and stay constant from grant until the request is dropped.
- State IDLE:
  - Grant only if some req_valid=1 AND mem_response=0. The second condition covers a reset applied while the memory still shows a response.
  - Winner is the first valid requester scanning from the pointer upward, with modulo-N_REQ wrap.
  - On grant: latch mode/addr/wdata into mem_*; set mem_request=1; pulse req_grant[w]; pointer <= w+1 (wraps); go to WAIT.
- State WAIT, on mem_response=1:
  - mem_request <= 0.
  - If mode is read, rdata <= mem_read_bus.
  - Pulse req_done[w]; go to RELEASE.
  - Dropping the request here, before the memory's next negedge clear, guarantees a single access per command.
- State RELEASE: wait for mem_response=0, then go to IDLE. This prevents the still-high response flag from being mistaken for the completion of the next command.
- Timing:
  - Nominal: grant at edge k, done at edge k+1, IDLE at edge k+2.
  - Minimum 3 cycles per access.
  - Back-to-back requests from the same requester are accepted no earlier than edge k+3.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,N_REQ-1,0,...
- req_valid deasserting before grant: no effect. Deasserting after grant: ignored; the latched command completes.
- Simultaneous done and new valid: the new request is not considered until IDLE.
- Reset in WAIT or RELEASE: immediate return to IDLE with mem_request=0. No req_done is issued for the aborted command. The next grant waits for mem_response=0.

Optional Feature:
MEM_ARB_TIMEOUT_EN:
- Defined:
  - A counter runs in WAIT.
  - If it reaches TIMEOUT with no mem_response, the arbiter drops mem_request, pulses err and req_done[w], leaves rdata unchanged and goes to RELEASE.
  - The counter clears on leaving WAIT.
- Undefined: no counter; WAIT is unbounded; err is constant 0.

Decomposition:
- Shared package: state encoding (IDLE/WAIT/RELEASE) and MMODE_READ=0 / MMODE_WRITE=1 constants, shared with the memory block.
- Natural sub-module rr_picker: combinational round-robin selector taking (valid vector, pointer) and returning (one-hot grant, index, any).

Test Plan:
- Single write then read: requester 0 writes 0xBEEF to 0x0010, then reads 0x0010 -> req_done[0] at grant+1 each time; rdata = 0xBEEF; exactly one memory write observed.
- Contention: both requesters valid continuously, requester 0 reading 0x0001..., requester 1 reading 0x8000... -> grants alternate 0,1,0,1; each access spans 3 cycles; no starvation over 20 accesses.
- Hold-over check: requester holds req_valid for 2 extra cycles after req_done -> second grant occurs only at edge k+3; mem_request is never high while mem_response is high in RELEASE.
- Reset mid-WAIT with a stub memory delaying its response by 5 cycles, reset at cycle 2 -> mem_request=0 next edge; no req_done; next grant only after mem_response is low.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT=15, stub memory never responds) -> err and req_done pulse at grant+15; rdata unchanged; arbiter returns to IDLE and serves the next request normally.
- Pointer wrap: N_REQ=3, only requester 2 valid, then requesters 0 and 2 valid -> requester 0 is granted before requester 2 is granted again.
